// File: rtl/reg_file_wb.sv
// 4-entry register file with a registered write-back stage and commit counter.
// Optional macro WB_FWD_EN forwards the pending write-back to read ports A and B.
module reg_file_wb #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] dbg_data,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    // capture the request into WB, commit the previous WB entry to the array
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wr_count <= '0;
        end else begin
            wb_valid <= wr_en;
            if (wr_en) begin
                wb_addr <= wr_addr;
                wb_data <= wr_data;
            end
            if (wb_valid) begin
                regs[wb_addr] <= wb_data;
                wr_count      <= wr_count + 1'b1;
            end
        end
    end

    // combinational reads; display port always sees the array only
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        dbg_data  = regs[dbg_addr];
`ifdef WB_FWD_EN
        if (wb_valid && (wb_addr == rd_addr_a)) begin
            rd_data_a = wb_data;
        end
        if (wb_valid && (wb_addr == rd_addr_b)) begin
            rd_data_b = wb_data;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: latency, back-to-back, same-address,
// reset while pending, and counter wrap.
module tb_reg_file_wb;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] rd_addr_a;
    logic [1:0] rd_addr_b;
    logic [1:0] dbg_addr;
    logic [7:0] rd_data_a;
    logic [7:0] rd_data_b;
    logic [7:0] dbg_data;
    logic       wb_valid;
    logic [7:0] wr_count;

    int n_cmp = 0;
    int n_err = 0;

`ifdef WB_FWD_EN
    localparam logic [7:0] EARLY_A5 = 8'hA5;
`else
    localparam logic [7:0] EARLY_A5 = 8'h00;
`endif

    reg_file_wb dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .dbg_addr  (dbg_addr),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .dbg_data  (dbg_data),
        .wb_valid  (wb_valid),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // one rising edge, inputs then stable 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic put(input logic [1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
    endtask

    task automatic idle(input int n);
        wr_en = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [7:0] exp_bank [4];

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        dbg_addr  = '0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        for (int i = 0; i < 4; i++) begin
            rd_addr_a = 2'(i);
            rd_addr_b = 2'(3 - i);
            dbg_addr  = 2'(i);
            #1;
            check("rst_a", rd_data_a, 0);
            check("rst_b", rd_data_b, 0);
            check("rst_dbg", dbg_data, 0);
        end
        check("rst_wbv", wb_valid, 0);
        check("rst_cnt", wr_count, 0);

        // write latency
        rd_addr_a = 2'd2;
        rd_addr_b = 2'd2;
        dbg_addr  = 2'd2;
        put(2'd2, 8'hA5);
        wr_en = 1'b0;
        #1;
        check("lat_wbv", wb_valid, 1);
        check("lat_a0", rd_data_a, EARLY_A5);
        check("lat_b0", rd_data_b, EARLY_A5);
        check("lat_dbg0", dbg_data, 8'h00);
        check("lat_cnt0", wr_count, 0);
        tick();
        check("lat_a1", rd_data_a, 8'hA5);
        check("lat_b1", rd_data_b, 8'hA5);
        check("lat_dbg1", dbg_data, 8'hA5);
        check("lat_cnt1", wr_count, 1);
        check("lat_wbv1", wb_valid, 0);

        // back-to-back
        do_reset();
        put(2'd0, 8'h11);
        put(2'd1, 8'h22);
        put(2'd2, 8'h33);
        put(2'd3, 8'h44);
        idle(2);
        exp_bank[0] = 8'h11;
        exp_bank[1] = 8'h22;
        exp_bank[2] = 8'h33;
        exp_bank[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            dbg_addr  = 2'(i);
            rd_addr_a = 2'(i);
            rd_addr_b = 2'(i);
            #1;
            check("b2b_dbg", dbg_data, exp_bank[i]);
            check("b2b_a", rd_data_a, exp_bank[i]);
            check("b2b_b", rd_data_b, exp_bank[i]);
        end
        check("b2b_cnt", wr_count, 4);

        // same address twice
        do_reset();
        dbg_addr = 2'd1;
        put(2'd1, 8'h01);
        put(2'd1, 8'h02);
        check("same_mid", dbg_data, 8'h01);
        check("same_midc", wr_count, 1);
        idle(1);
        check("same_fin", dbg_data, 8'h02);
        check("same_cnt", wr_count, 2);

        // reset while a write is pending
        do_reset();
        dbg_addr = 2'd3;
        put(2'd3, 8'hFF);
        do_reset();
        check("rmid_r3", dbg_data, 0);
        check("rmid_wbv", wb_valid, 0);
        check("rmid_cnt", wr_count, 0);
        idle(2);
        check("rmid_r3b", dbg_data, 0);
        check("rmid_cntb", wr_count, 0);

        // reset dominates wr_en
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 2'd3;
        wr_data = 8'h5A;
        tick();
        reset = 1'b0;
        wr_en = 1'b0;
        check("rdom_wbv", wb_valid, 0);
        tick();
        check("rdom_r3", dbg_data, 0);
        check("rdom_cnt", wr_count, 0);

        // counter wrap
        do_reset();
        for (int i = 0; i < 255; i++) put(2'(i), 8'(i));
        idle(1);
        check("wrap_255", wr_count, 255);
        put(2'd0, 8'h77);
        idle(1);
        check("wrap_256", wr_count, 0);
        put(2'd1, 8'h88);
        idle(1);
        check("wrap_257", wr_count, 1);
        dbg_addr = 2'd1;
        #1;
        check("wrap_r1", dbg_data, 8'h88);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
